dot_accumulator: RTL

Sequential fixed-point accumulator that sits directly downstream of the saturating Q-format multiplier in the LSTM gate datapath. It consumes a stream of LEN products (with their per-product overflow flags), adds them to a bias in a guard-bit-extended accumulator, and emits one saturated WIDTH-bit dot-product result per vector. Input and output use valid/ready handshakes so the block can be stalled by either neighbour.

---
 rtl/dot_accumulator_if.sv | 31 +++
 rtl/dot_accumulator.sv | 116 +++++++++++
 2 files changed

// File: rtl/dot_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_accumulator_if
// Description : Product-in / result-out handshake bundle for dot_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_accumulator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] bias;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] prod;
    logic             prod_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             overflow;

    modport master (
        output start, bias, in_valid, prod, prod_ovf, out_ready,
        input  in_ready, out_valid, sum, overflow
    );

    modport slave (
        input  start, bias, in_valid, prod, prod_ovf, out_ready,
        output in_ready, out_valid, sum, overflow
    );
endinterface
`default_nettype wire

// File: rtl/dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : dot_accumulator
// Description : Accumulates LEN Q-format products onto a bias with guard bits,
//               saturating once per vector into a WIDTH-bit result.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_accumulator #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8,
    parameter int LEN       = 4
) (
    input  wire                    clk,
    input  wire                    rst_n,
    dot_accumulator_if.slave       bus
);

    localparam int c_guard     = $clog2(LEN + 1);
    localparam int c_acc_width = WIDTH + c_guard;
    localparam int c_cnt_width = (LEN > 1) ? $clog2(LEN) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    if (LEN < 1 || FRAC_BITS > WIDTH) begin : g_param_check
        $error("dot_accumulator: LEN must be >= 1 and FRAC_BITS <= WIDTH");
    end

    logic [1:0]             r_state;
    logic [c_acc_width-1:0] r_acc;
    logic [c_cnt_width-1:0] r_cnt;
    logic                   r_ovf;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_overflow;

    logic [c_acc_width-1:0] w_bias_ext;
    logic [c_acc_width-1:0] w_prod_ext;
    logic [c_acc_width-1:0] w_acc_next;
    logic                   w_ovf_next;
    logic [c_guard:0]       w_top;
    logic                   w_sat;
    logic [WIDTH-1:0]       w_sum_sat;
    logic                   w_last;

    assign w_bias_ext = {{c_guard{bus.bias[WIDTH-1]}}, bus.bias};
    assign w_prod_ext = {{c_guard{bus.prod[WIDTH-1]}}, bus.prod};
    assign w_acc_next = r_acc + w_prod_ext;
    assign w_ovf_next = r_ovf | bus.prod_ovf;

    // The value fits in WIDTH bits only when every bit above the result's
    // sign bit matches it.
    assign w_top     = w_acc_next[c_acc_width-1:WIDTH-1];
    assign w_sat     = ~((&w_top) | ~(|w_top));
    assign w_sum_sat = !w_sat                   ? w_acc_next[WIDTH-1:0] :
                       w_acc_next[c_acc_width-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                                   {1'b0, {(WIDTH-1){1'b1}}};
    assign w_last    = (r_cnt == c_cnt_width'(LEN - 1));

    assign bus.in_ready  = (r_state == c_st_accum);
    assign bus.out_valid = (r_state == c_st_done);
    assign bus.sum       = r_sum;
    assign bus.overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_sum      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_acc   <= w_bias_ext;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= c_st_accum;
                    end
                end
                c_st_accum: begin
                    if (bus.in_valid) begin
                        r_acc <= w_acc_next;
                        r_ovf <= w_ovf_next;
                        r_cnt <= r_cnt + c_cnt_width'(1);
                        if (w_last) begin
                            r_sum      <= w_sum_sat;
                            r_overflow <= w_ovf_next | w_sat;
                            r_state    <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    // A start coincident with the output handshake skips IDLE.
                    if (bus.out_ready) begin
                        if (bus.start) begin
                            r_acc   <= w_bias_ext;
                            r_cnt   <= '0;
                            r_ovf   <= 1'b0;
                            r_state <= c_st_accum;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
